car_lamp_ctrl: RTL and testbench
================================

CAR_LAMP_CTRL -- requirements
Module: car_lamp_ctrl

Interface
REQ-001 Parameter LAMP_W, default 3, lamps per side; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 25000000, clocks per animation step; legal range 2..2^26.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 turn_l  input  1  left-turn request, level.
REQ-006 turn_r  input  1  right-turn request, level.
REQ-007 hazard  input  1  hazard request, level.
REQ-008 brake  input  1  brake pedal, level.
REQ-009 door  input  1  door-open, level.
REQ-010 ledL  output  LAMP_W  left lamps, active-high; bit 0 innermost.
REQ-011 ledR  output  LAMP_W  right lamps, active-high; bit 0 innermost.
REQ-012 seg_mode  output  7  mode digit, active-high segments, bit order gfedcba.

Function
REQ-013 Mode FSM SHALL have states IDLE, LEFT, RIGHT, HAZ, DOOR; next mode by fixed priority: door->DOOR; else hazard or (turn_l and turn_r)->HAZ; else turn_l->LEFT; else turn_r->RIGHT; else IDLE.
REQ-014 Mode register SHALL load every clock; input-to-output latency exactly one clock; outputs are decoded from registers only, with no combinational path from inputs.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high for the one cycle where the count equals TICK_DIV-1.
REQ-016 Step counter SHALL range 0..LAMP_W, advance on tick, and wrap LAMP_W->0 (period LAMP_W+1 ticks).
REQ-017 Sweep pattern SHALL be a thermometer of width step from bit 0: step 0 all off; step LAMP_W all on.
REQ-018 On any mode change, prescaler and step SHALL clear to 0 on the same edge; a change coinciding with tick SHALL take priority over the step advance.
REQ-019 LEFT: ledL shows the sweep; RIGHT: ledR shows the sweep; HAZ: both sides show the identical sweep, phase-locked.
REQ-020 DOOR: both sides SHALL be all off at step 0 and toggle all-on/all-off on every tick; brake is ignored.
REQ-021 Brake, in IDLE/LEFT/RIGHT, SHALL force any non-sweeping side to all-on; a sweeping side keeps the sweep; in HAZ brake has no effect.
REQ-022 seg_mode: IDLE with brake low 0000000; IDLE with brake high 1111100 ('b'); LEFT 0111000 ('L'); RIGHT 1010000 ('r'); HAZ 1110110 ('H'); DOOR 1011110 ('d').

Reset
REQ-023 With rst high at an edge: mode IDLE, prescaler 0, step 0, DOOR phase off; ledL, ledR, seg_mode all 0 from the following cycle; rst overrides all inputs.
REQ-024 Reset asserted mid-sweep SHALL abort the sweep; after release, the first cycle restarts from step 0 of whatever mode the inputs select.

Configuration
REQ-025 Macro CAR_LAMP_SEG_EN: when defined, seg_mode SHALL be generated per REQ-022; when undefined, the seg decode logic is absent, the seg_mode port stays, and it is driven constant 7'b0000000; lamp behaviour is identical in both builds.

Structure
REQ-026 Package car_lamp_pkg SHALL hold the mode enum (IDLE, LEFT, RIGHT, HAZ, DOOR) and the six seg_mode code constants.
REQ-027 Sub-module lamp_tick_gen (parameter TICK_DIV; ports clk, rst, clr, tick) SHALL implement the prescaler; the top holds the FSM, step counter and decode.

Verification (LAMP_W=3, TICK_DIV=4 unless stated)
REQ-028 Reset, then turn_l=1 held: ledL steps 000,001,011,111,000 with each value lasting 4 clocks; ledR=000 throughout; seg_mode=0111000.
REQ-029 turn_l=turn_r=1: ledL==ledR every cycle, following 000,001,011,111 and repeating; seg_mode=1110110; then hazard=1 alone gives the same result.
REQ-030 brake=1 with turn_r=1: ledL=111 steady and ledR sweeping; brake=1 alone: both sides 111 and seg_mode=1111100.
REQ-031 door=1 raised while LEFT is at step 2: next cycle both sides 000, then 111 after 4 clocks, alternating; brake toggling has no effect; seg_mode=1011110.
REQ-032 rst pulsed mid-sweep at step 3, and separately turn_r released on a tick cycle: next cycle all outputs 0 and step 0, with no stray advance.
REQ-033 LAMP_W=5: ledL period 6 ticks, reaching 11111; with CAR_LAMP_SEG_EN undefined, seg_mode=0 in all of the above scenarios.

Source files
------------

// File: rtl/car_lamp_pkg.sv
// Shared types and constants for the car lamp controller.
// Holds the mode enum, the seg_mode glyph codes and the mode-priority helper.
package car_lamp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        HAZ   = 3'd3,
        DOOR  = 3'd4
    } modeT;

    // Seven-segment glyphs, bit order gfedcba, active-high.
    localparam logic [6:0] SegIdle  = 7'b0000000;
    localparam logic [6:0] SegBrake = 7'b1111100;
    localparam logic [6:0] SegLeft  = 7'b0111000;
    localparam logic [6:0] SegRight = 7'b1010000;
    localparam logic [6:0] SegHaz   = 7'b1110110;
    localparam logic [6:0] SegDoor  = 7'b1011110;

    // Fixed priority: door, hazard (or both turns), left, right, idle.
    function automatic modeT pickMode(
        input logic door,
        input logic hazard,
        input logic turnL,
        input logic turnR
    );
        if (door)
            return DOOR;
        else if (hazard || (turnL && turnR))
            return HAZ;
        else if (turnL)
            return LEFT;
        else if (turnR)
            return RIGHT;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// Animation prescaler: counts 0..TICK_DIV-1 and wraps.
// Ports: clk, rst (sync, high), clr (restart count), tick (high when count==TICK_DIV-1).
module lamp_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (cnt == CntMax)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CntMax);

endmodule

// File: rtl/car_lamp_ctrl.sv
// Car lamp controller: turn/hazard sweeps, brake override, door flash, mode digit.
// Ports: clk, rst (sync, high), turn_l, turn_r, hazard, brake, door in;
//        ledL/ledR [LAMP_W] lamps (bit 0 innermost), seg_mode [7] gfedcba digit.
// Macro CAR_LAMP_SEG_EN enables the seg_mode decode; otherwise seg_mode is 0.
module car_lamp_ctrl
    import car_lamp_pkg::*;
#(
    parameter int LAMP_W   = 3,
    parameter int TICK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              turn_l,
    input  logic              turn_r,
    input  logic              hazard,
    input  logic              brake,
    input  logic              door,
    output logic [LAMP_W-1:0] ledL,
    output logic [LAMP_W-1:0] ledR,
    output logic [6:0]        seg_mode
);

    localparam int StepW = $clog2(LAMP_W + 1);
    localparam logic [StepW-1:0] StepMax = StepW'(LAMP_W);

    modeT mode;
    modeT modeNext;
    logic modeChg;
    logic tick;
    logic [StepW-1:0] step;
    logic doorPhase;
    // Brake is registered so every output derives from state only.
    logic brakeQ;
    logic [LAMP_W-1:0] sweep;

    always_ff @(posedge clk) begin
        if (rst)
            mode <= IDLE;
        else
            mode <= modeNext;
    end

    always_comb begin
        modeNext = pickMode(door, hazard, turn_l, turn_r);
        modeChg  = (modeNext != mode);
    end

    lamp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) uTick (
        .clk  (clk),
        .rst  (rst),
        .clr  (modeChg),
        .tick (tick)
    );

    // A mode change beats a coincident tick so the new mode starts at step 0.
    always_ff @(posedge clk) begin
        if (rst || modeChg) begin
            step      <= '0;
            doorPhase <= 1'b0;
        end else if (tick) begin
            step      <= (step == StepMax) ? '0 : step + 1'b1;
            doorPhase <= (mode == DOOR) ? ~doorPhase : doorPhase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            brakeQ <= 1'b0;
        else
            brakeQ <= brake;
    end

    always_comb begin
        sweep = '0;
        for (int i = 0; i < LAMP_W; i++)
            sweep[i] = (StepW'(i) < step);
    end

    always_comb begin
        ledL = '0;
        ledR = '0;
        unique case (mode)
            LEFT: begin
                ledL = sweep;
                ledR = {LAMP_W{brakeQ}};
            end
            RIGHT: begin
                ledL = {LAMP_W{brakeQ}};
                ledR = sweep;
            end
            HAZ: begin
                ledL = sweep;
                ledR = sweep;
            end
            DOOR: begin
                ledL = {LAMP_W{doorPhase}};
                ledR = {LAMP_W{doorPhase}};
            end
            default: begin
                ledL = {LAMP_W{brakeQ}};
                ledR = {LAMP_W{brakeQ}};
            end
        endcase
    end

`ifdef CAR_LAMP_SEG_EN
    always_comb begin
        seg_mode = SegIdle;
        unique case (mode)
            LEFT:    seg_mode = SegLeft;
            RIGHT:   seg_mode = SegRight;
            HAZ:     seg_mode = SegHaz;
            DOOR:    seg_mode = SegDoor;
            default: seg_mode = brakeQ ? SegBrake : SegIdle;
        endcase
    end
`else
    assign seg_mode = 7'b0000000;
`endif

endmodule

// File: tb/tb_car_lamp_ctrl.sv
// Randomized scoreboard bench for car_lamp_ctrl at LAMP_W=3 and LAMP_W=5.
// Expected lamps come from elapsed-time arithmetic per mode.
module tb_car_lamp_ctrl;

    localparam int TD = 4;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
        logic [7:0] s;
    } expT;

    localparam int MIdle  = 0;
    localparam int MLeft  = 1;
    localparam int MRight = 2;
    localparam int MHaz   = 3;
    localparam int MDoor  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic turnL = 1'b0;
    logic turnR = 1'b0;
    logic hazard = 1'b0;
    logic brake = 1'b0;
    logic door = 1'b0;

    logic [2:0] ledL3;
    logic [2:0] ledR3;
    logic [6:0] seg3;
    logic [4:0] ledL5;
    logic [4:0] ledR5;
    logic [6:0] seg5;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    expT q3[$];
    expT q5[$];

    int mMode = MIdle;
    int elapsed = 0;
    bit mBrk = 1'b0;

    always #5 clk = ~clk;

    car_lamp_ctrl #(
        .LAMP_W   (3),
        .TICK_DIV (TD)
    ) dut3 (
        .clk      (clk),
        .rst      (rst),
        .turn_l   (turnL),
        .turn_r   (turnR),
        .hazard   (hazard),
        .brake    (brake),
        .door     (door),
        .ledL     (ledL3),
        .ledR     (ledR3),
        .seg_mode (seg3)
    );

    car_lamp_ctrl #(
        .LAMP_W   (5),
        .TICK_DIV (TD)
    ) dut5 (
        .clk      (clk),
        .rst      (rst),
        .turn_l   (turnL),
        .turn_r   (turnR),
        .hazard   (hazard),
        .brake    (brake),
        .door     (door),
        .ledL     (ledL5),
        .ledR     (ledR5),
        .seg_mode (seg5)
    );

    function automatic expT model(int w, int md, int e, bit brk);
        expT x;
        int ticks;
        int st;
        int therm;
        int full;
        int onOff;
        ticks = e / TD;
        st = ticks % (w + 1);
        therm = (1 << st) - 1;
        full = (1 << w) - 1;
        onOff = brk ? full : 0;
        x.s = 8'h00;
        case (md)
            MLeft:  begin x.l = 8'(therm); x.r = 8'(onOff); end
            MRight: begin x.l = 8'(onOff); x.r = 8'(therm); end
            MHaz:   begin x.l = 8'(therm); x.r = 8'(therm); end
            MDoor:  begin
                x.l = (ticks % 2 == 1) ? 8'(full) : 8'h00;
                x.r = x.l;
            end
            default: begin x.l = 8'(onOff); x.r = 8'(onOff); end
        endcase
`ifdef CAR_LAMP_SEG_EN
        case (md)
            MLeft:   x.s = 8'b00111000;
            MRight:  x.s = 8'b01010000;
            MHaz:    x.s = 8'b01110110;
            MDoor:   x.s = 8'b01011110;
            default: x.s = brk ? 8'b01111100 : 8'b00000000;
        endcase
`endif
        return x;
    endfunction

    // Advance the model across the coming clock edge and queue expectations.
    task automatic modelEdge();
        int nm;
        if (door)
            nm = MDoor;
        else if (hazard || (turnL && turnR))
            nm = MHaz;
        else if (turnL)
            nm = MLeft;
        else if (turnR)
            nm = MRight;
        else
            nm = MIdle;
        if (rst) begin
            mMode = MIdle;
            elapsed = 0;
            mBrk = 1'b0;
        end else begin
            if (nm != mMode) begin
                mMode = nm;
                elapsed = 0;
            end else begin
                elapsed++;
            end
            mBrk = brake;
        end
        q3.push_back(model(3, mMode, elapsed, mBrk));
        q5.push_back(model(5, mMode, elapsed, mBrk));
    endtask

    // v = {rst, door, brake, hazard, turn_r, turn_l}
    task automatic runFor(int n, logic [5:0] v, bit jitterBrake);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            {rst, door, brake, hazard, turnR, turnL} = v;
            if (jitterBrake)
                brake = 1'($urandom_range(0, 1));
            modelEdge();
        end
    endtask

    task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("ledL_w3", {5'b0, ledL3}, e.l);
                check("ledR_w3", {5'b0, ledR3}, e.r);
                check("seg_w3", {1'b0, seg3}, e.s);
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                check("ledL_w5", {3'b0, ledL5}, e.l);
                check("ledR_w5", {3'b0, ledR5}, e.r);
                check("seg_w5", {1'b0, seg5}, e.s);
            end
        end
    end

    initial begin : stim
        logic [5:0] v;
        runFor(3, 6'b100000, 1'b0);
        runFor(40, 6'b000001, 1'b0);
        runFor(36, 6'b000011, 1'b0);
        runFor(36, 6'b000100, 1'b0);
        runFor(30, 6'b001010, 1'b0);
        runFor(10, 6'b001000, 1'b0);
        runFor(9, 6'b000001, 1'b0);
        runFor(30, 6'b010000, 1'b1);
        runFor(15, 6'b000001, 1'b0);
        runFor(1, 6'b100001, 1'b0);
        runFor(20, 6'b000001, 1'b0);
        runFor(11, 6'b000010, 1'b0);
        runFor(5, 6'b000000, 1'b0);
        runFor(60, 6'b000001, 1'b0);
        for (int s = 0; s < 150; s++) begin
            v = '0;
            v[5] = ($urandom_range(0, 11) == 0);
            v[4] = ($urandom_range(0, 5) == 0);
            v[3] = ($urandom_range(0, 2) == 0);
            v[2] = ($urandom_range(0, 4) == 0);
            v[1] = ($urandom_range(0, 1) == 0);
            v[0] = ($urandom_range(0, 1) == 0);
            if (v[5])
                runFor($urandom_range(1, 2), v, 1'b0);
            else
                runFor($urandom_range(1, 60), v,
                       ($urandom_range(0, 3) == 0));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q3.size() != 0 || q5.size() != 0) begin
            failures++;
            $display("FAIL drain q3=%0d q5=%0d exp=0", q3.size(), q5.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
